// File: rtl/pulse_stretcher_pkg.sv
// Shared types for the pulse stretcher.
//   state_t : controller state (IDLE, HOLD, COOL)
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        COOL = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/level bundle between a requester and the pulse stretcher.
//   trig    : trigger request, sampled every cycle
//   len     : hold length in cycles, sampled only when trig is accepted
//   out     : stretched level
//   busy    : stretcher is not idle
//   dropped : one-cycle flag, a trig was rejected on the previous cycle
interface pulse_stretcher_if #(
    parameter int CW = 16
) ();
    logic          trig;
    logic [CW-1:0] len;
    logic          out;
    logic          busy;
    logic          dropped;

    modport master (output trig, output len, input out, input busy, input dropped);
    modport slave  (input trig, input len, output out, output busy, output dropped);
endinterface

// File: rtl/load_down_counter.sv
// Loadable down-counter with an is-one flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; ignored when the count is already zero
//   cnt        : current count
//   is_one     : count equals one (final cycle of a timed phase)
module load_down_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          is_one
);

    logic [CW-1:0] r_cnt;

    // Decrement is suppressed at zero so the counter can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign cnt    = r_cnt;
    assign is_one = (r_cnt == CW'(1));

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a high level of programmable length,
// with optional retriggering and an optional post-hold cooldown window.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pulse_stretcher_if (trig, len in; out, busy, dropped out)
// Parameters: CW counter/len width, RETRIGGER reload on trig during hold,
// COOLDOWN forced-low cycles after each hold (0 = none).
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int CW        = 16,
    parameter int RETRIGGER = 1,
    parameter int COOLDOWN  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    pulse_stretcher_if.slave  bus
);

    localparam logic [CW-1:0] COOL_VAL = CW'(COOLDOWN);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_dropped;
    logic          w_dropped_nxt;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_dec;
    logic [CW-1:0] w_cnt;
    logic          w_is_one;
    logic [CW-1:0] w_len_eff;

    // A zero length still yields a one-cycle hold.
    assign w_len_eff = (bus.len == '0) ? CW'(1) : bus.len;

    load_down_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (w_dec),
        .cnt      (w_cnt),
        .is_one   (w_is_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_dropped <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dropped <= w_dropped_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_val    = w_len_eff;
        w_dec         = 1'b0;
        w_dropped_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.trig) begin
                    w_state_nxt = HOLD;
                    w_load      = 1'b1;
                end
            end
            HOLD: begin
                // Reload wins over expiry, so a trig on the last hold cycle extends it.
                if (bus.trig && (RETRIGGER != 0)) begin
                    w_load = 1'b1;
                end else begin
                    w_dropped_nxt = bus.trig;
                    if (w_is_one) begin
                        if (COOLDOWN > 0) begin
                            w_state_nxt = COOL;
                            w_load      = 1'b1;
                            w_load_val  = COOL_VAL;
                        end else begin
                            w_state_nxt = IDLE;
                            w_dec       = 1'b1;
                        end
                    end else begin
                        w_dec = (w_cnt != '0);
                    end
                end
            end
            COOL: begin
                w_dropped_nxt = bus.trig;
                w_dec         = (w_cnt != '0);
                if (w_is_one) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only, so they cannot glitch.
    assign bus.out     = (r_state == HOLD);
    assign bus.busy    = (r_state != IDLE);
    assign bus.dropped = r_dropped;

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pulse_stretcher_if #(.CW(16)) bus_a ();
    pulse_stretcher_if #(.CW(16)) bus_b ();

    // A: retrigger, no cooldown.  B: no retrigger, 3-cycle cooldown.
    pulse_stretcher #(.CW(16), .RETRIGGER(1), .COOLDOWN(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );
    pulse_stretcher #(.CW(16), .RETRIGGER(0), .COOLDOWN(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Expected triplet encoding {out, busy, dropped}
    localparam logic [2:0] I  = 3'b000;
    localparam logic [2:0] ID = 3'b001;
    localparam logic [2:0] C  = 3'b010;
    localparam logic [2:0] CD = 3'b011;
    localparam logic [2:0] H  = 3'b110;
    localparam logic [2:0] HD = 3'b111;

    typedef struct {
        bit         dut;
        logic [2:0] exp;
        int         tnum;
        int         vnum;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   tnum  = 0;
    int   vnum  = 0;

    task automatic cmp(input string name, input logic [2:0] act, input logic [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {out,busy,dropped}=%b expected=%b", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus to the selected DUT and queue the outputs
    // expected right after the next rising edge.
    task automatic step(input bit d, input bit t, input int l, input logic [2:0] e);
        exp_t x;
        @(negedge clk);
        if (d) begin
            bus_b.trig = t;
            bus_b.len  = 16'(l);
            bus_a.trig = 1'b0;
        end else begin
            bus_a.trig = t;
            bus_a.len  = 16'(l);
            bus_b.trig = 1'b0;
        end
        x.dut  = d;
        x.exp  = e;
        x.tnum = tnum;
        x.vnum = vnum;
        sbq.push_back(x);
        vnum++;
    endtask

    task automatic new_test(input int n);
        tnum = n;
        vnum = 0;
    endtask

    // Monitor: one queued expectation per clock, compared just after the edge.
    always begin
        exp_t       e;
        logic [2:0] act;
        @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            e   = sbq.pop_front();
            act = e.dut ? {bus_b.out, bus_b.busy, bus_b.dropped}
                        : {bus_a.out, bus_a.busy, bus_a.dropped};
            cmp($sformatf("t%0d_v%0d_dut%0d", e.tnum, e.vnum, e.dut), act, e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.trig = 1'b0;
        bus_a.len  = '0;
        bus_b.trig = 1'b0;
        bus_b.len  = '0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        cmp("reset_a", {bus_a.out, bus_a.busy, bus_a.dropped}, I);
        cmp("reset_b", {bus_b.out, bus_b.busy, bus_b.dropped}, I);
        rst_n = 1'b1;

        // len=5 pulse; len changes while holding are ignored
        new_test(1);
        step(0, 1, 5, H);
        repeat (4) step(0, 0, 9, H);
        step(0, 0, 9, I);

        // len=0 gives one cycle, then len=3 after a one-cycle gap
        new_test(2);
        step(0, 1, 0, H);
        step(0, 0, 0, I);
        step(0, 1, 3, H);
        step(0, 0, 0, H);
        step(0, 0, 0, H);
        step(0, 0, 0, I);

        // retrigger on the third high cycle -> 7 cycles high
        new_test(3);
        step(0, 1, 4, H);
        step(0, 0, 0, H);
        step(0, 0, 0, H);
        step(0, 1, 4, H);
        repeat (3) step(0, 0, 0, H);
        step(0, 0, 0, I);

        // retrigger on the final hold cycle extends the hold
        new_test(4);
        step(0, 1, 2, H);
        step(0, 0, 0, H);
        step(0, 1, 2, H);
        step(0, 0, 0, H);
        step(0, 0, 0, I);

        // trig held for 6 cycles, len=2 -> 7 cycles high
        new_test(5);
        repeat (6) step(0, 1, 2, H);
        step(0, 0, 2, H);
        step(0, 0, 2, I);

        // no retrigger, cooldown 3: drops during hold and every cool cycle
        new_test(6);
        step(1, 1, 4, H);
        step(1, 1, 4, HD);
        step(1, 0, 4, H);
        step(1, 0, 4, H);
        step(1, 1, 4, CD);
        step(1, 1, 4, CD);
        step(1, 1, 4, CD);
        step(1, 1, 4, ID);
        step(1, 1, 4, H);
        step(1, 0, 4, H);
        step(1, 0, 4, H);
        step(1, 0, 4, H);
        step(1, 0, 4, C);
        step(1, 0, 4, C);
        step(1, 0, 4, C);
        step(1, 0, 4, I);

        // asynchronous reset in the middle of a len=10 hold
        new_test(7);
        step(0, 1, 10, H);
        step(0, 0, 10, H);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("midhold_reset_a", {bus_a.out, bus_a.busy, bus_a.dropped}, I);
        cmp("midhold_reset_b", {bus_b.out, bus_b.busy, bus_b.dropped}, I);
        @(negedge clk);
        rst_n = 1'b1;
        new_test(8);
        step(0, 1, 10, H);
        repeat (9) step(0, 0, 10, H);
        step(0, 0, 10, I);

        @(negedge clk);
        bus_a.trig = 1'b0;
        bus_b.trig = 1'b0;
        for (int i = 0; i < 10 && sbq.size() != 0; i++) @(posedge clk);
        #2;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts a single-cycle trigger pulse into a sustained high level of programmable length, the inverse of the level-to-one-shot trigger conditioning used on button inputs. It drives effects and display logic that need a request held for a known number of cycles, such as timed animation phases or a screen-blank window. Supports optional retriggering and a post-pulse cooldown during which new triggers are rejected and flagged.

## Interface
- CW, 16: width of the length input and internal counter.
- RETRIGGER, 1: 1 = trigger during hold reloads the count; 0 = trigger during hold is dropped.
- COOLDOWN, 0: cycles of forced low output after each hold; 0 = no cooldown state; must be < 2**CW.

- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- trig  input  1  trigger request, sampled every cycle (normally a one-cycle pulse).
- len  input  CW  hold length in cycles, sampled only on the cycle trig is accepted.
- out  output  1  stretched level.
- busy  output  1  high whenever state is not IDLE.
- dropped  output  1  registered one-cycle pulse: a trig was rejected the previous cycle.

## Operation
- States: IDLE, HOLD, COOL. One down-counter cnt[CW-1:0].
- Effective length L = (len == 0) ? 1 : len.
- IDLE: trig -> HOLD, cnt <= L. No trig -> stay.
- HOLD: out = 1.
  - trig and RETRIGGER=1 -> cnt <= L, stay HOLD (no gap in out).
  - trig and RETRIGGER=0 -> dropped next cycle; counting continues unaffected.
  - no reload and cnt == 1 -> COOL with cnt <= COOLDOWN if COOLDOWN > 0, else IDLE.
  - otherwise cnt <= cnt - 1.
- COOL: out = 0; every trig drops, including on the final cycle. cnt == 1 -> IDLE, else decrement.
- Retrigger takes priority over expiry: trig on the last HOLD cycle with RETRIGGER=1 extends the hold.
- trig held high continuously: IDLE accepts once. With RETRIGGER=1, HOLD reloads every cycle and out stays high for L cycles after trig falls. With RETRIGGER=0, dropped pulses every cycle trig is high after acceptance.
- out = (state == HOLD); busy = (state != IDLE). Both decode registered state only, so they are glitch-free.
- cnt never wraps: it is never decremented at 0, and reloads use L >= 1.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, cnt = 0, out = 0, busy = 0, dropped = 0, all immediately on rst_n low. Reset mid-hold truncates out at once.
- Latency: trig accepted at edge t -> out high from cycle t+1 through t+L inclusive, exactly L cycles.
- Retrigger accepted at edge r -> out stays high through cycle r+L.
- COOL spans COOLDOWN cycles after the last out-high cycle. The first accepted trig is on the cycle after COOL ends.
- dropped is asserted the cycle after the rejected trig, for one cycle per rejected trig.
- len is sampled only at acceptance or reload; len changes at other times have no effect.

## Structure
- Package pulse_stretcher_pkg: state_t enum {IDLE, HOLD, COOL}.
- One natural sub-module: load_down_counter, with ports clk, rst_n, load, load_val, dec, out cnt, and is_one. The FSM stays in the top.

## Test plan
- CW=16, RETRIGGER=1, COOLDOWN=0; trig pulse with len=5 -> out high exactly 5 cycles starting the cycle after trig, busy identical, dropped never high.
- len=0 pulse -> out high exactly 1 cycle; trig two cycles later with len=3 -> out high 3 cycles with a 1-cycle low gap between.
- RETRIGGER=1, len=4, second trig on 3rd out-high cycle with len=4 -> out continuously high for 7 cycles total; retrigger on final HOLD cycle also extends.
- RETRIGGER=0, COOLDOWN=3, len=4; trigs during HOLD and during each COOL cycle -> dropped pulses one cycle after each, out high 4 cycles, then low 3 cycles of busy, then trig accepted.
- rst_n pulled low on 2nd cycle of a len=10 hold -> out, busy, dropped are 0 immediately; after release, the next trig gives a full 10-cycle hold.
- trig held high for 6 cycles, len=2, RETRIGGER=1 -> out high from cycle after first trig until 2 cycles after trig falls (7 cycles total).
